mem_exception_cp0: RTL and testbench

MEM-stage exception commit and coprocessor-0 register file. Consumes the 9-bit exception vector that the EX stage produces (overflow already merged) as it arrives through the EX/MEM register. Prioritises one exception or an ERET and raises a pipeline flush with a redirect PC in the same cycle. Updates EPC/Cause/Status/BadVAddr on the following clock edge.

---
 rtl/cp0_pkg.sv | 40 ++++
 rtl/exc_priority_enc.sv | 44 ++++
 rtl/mem_exception_cp0.sv | 178 +++++++++++++++++
 tb/tb_mem_exception_cp0.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, ExcCodes, exception-vector bit
// positions (also used by decode and the EX overflow stage) and field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int EXV_FETCH_ADEL = 0;
    localparam int EXV_RI         = 1;
    localparam int EXV_SYS        = 2;
    localparam int EXV_BP         = 3;
    localparam int EXV_ERET       = 4;
    localparam int EXV_OV         = 5;
    localparam int EXV_LOAD_ADEL  = 6;
    localparam int EXV_STORE_ADES = 7;
    localparam int EXV_RSVD       = 8;
    localparam int EXV_WIDTH      = 9;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_BEV   = 22;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational exception prioritiser for the MEM slot: picks at most one
// exception (interrupt first) and reports an ERET only when nothing else fires.
module exc_priority_enc
    import cp0_pkg::*;
(
    input  logic                 in_valid,
    input  logic [EXV_WIDTH-1:0] in_except,
    input  logic                 int_pending,
    output logic                 take,
    output logic                 eret,
    output logic [4:0]           exc_code,
    output logic                 use_data_addr
);

    logic unused_rsvd;
    assign unused_rsvd = in_except[EXV_RSVD];

    always_comb begin
        take          = 1'b0;
        eret          = 1'b0;
        exc_code      = EXC_INT;
        use_data_addr = 1'b0;
        if (in_valid) begin
            take = 1'b1;
            if (int_pending)                      exc_code = EXC_INT;
            else if (in_except[EXV_FETCH_ADEL])   exc_code = EXC_ADEL;
            else if (in_except[EXV_RI])           exc_code = EXC_RI;
            else if (in_except[EXV_SYS])          exc_code = EXC_SYS;
            else if (in_except[EXV_BP])           exc_code = EXC_BP;
            else if (in_except[EXV_OV])           exc_code = EXC_OV;
            else if (in_except[EXV_LOAD_ADEL]) begin
                exc_code      = EXC_ADEL;
                use_data_addr = 1'b1;
            end else if (in_except[EXV_STORE_ADES]) begin
                exc_code      = EXC_ADES;
                use_data_addr = 1'b1;
            end else begin
                take = 1'b0;
                eret = in_except[EXV_ERET];
            end
        end
    end

endmodule

// File: rtl/mem_exception_cp0.sv
// MEM-stage exception commit plus CP0 register file (BadVAddr/Count/Compare/
// Status/Cause/EPC). Optional timer enabled by defining CP0_TIMER_EN.
module mem_exception_cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [EXV_WIDTH-1:0] in_except,
    input  logic [31:0]          in_pc,
    input  logic                 in_delay_slot,
    input  logic [31:0]          in_bad_vaddr,
    input  logic [5:0]           hw_int,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_waddr,
    input  logic [31:0]          cp0_wdata,
    input  logic [4:0]           cp0_raddr,
    output logic [31:0]          cp0_rdata,
    output logic                 flush,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          epc_o,
    output logic [31:0]          status_o,
    output logic [31:0]          cause_o
);

    logic [7:0]  status_im_reg;
    logic        status_exl_reg;
    logic        status_ie_reg;
    logic        cause_bd_reg;
    logic [1:0]  cause_ip_sw_reg;
    logic [5:0]  hw_int_reg;
    logic [4:0]  cause_exc_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;

    logic        ti_bit;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic [7:0]  cause_ip;
    logic        int_pending;
    logic        enc_take;
    logic        enc_eret;
    logic [4:0]  exc_code;
    logic        use_data_addr;
    logic        take;
    logic        eret;
    logic        mtc0_ok;

    assign cause_ip    = {hw_int_reg[5] | ti_bit, hw_int_reg[4:0], cause_ip_sw_reg};
    assign int_pending = status_ie_reg & ~status_exl_reg & (|(cause_ip & status_im_reg));

    exc_priority_enc u_enc (
        .in_valid      (in_valid),
        .in_except     (in_except),
        .int_pending   (int_pending),
        .take          (enc_take),
        .eret          (enc_eret),
        .exc_code      (exc_code),
        .use_data_addr (use_data_addr)
    );

    // Reset kills the in-flight exception/ERET immediately, not at the next edge.
    assign take        = enc_take & ~rst;
    assign eret        = enc_eret & ~rst;
    assign mtc0_ok     = mtc0_we & ~take & ~eret;
    assign flush       = take | eret;
    assign redirect_pc = take ? EXC_VECTOR : (eret ? epc_reg : 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_im_reg   <= '0;
            status_exl_reg  <= 1'b0;
            status_ie_reg   <= 1'b0;
            cause_bd_reg    <= 1'b0;
            cause_ip_sw_reg <= '0;
            hw_int_reg      <= '0;
            cause_exc_reg   <= '0;
            epc_reg         <= '0;
            badvaddr_reg    <= '0;
        end else begin
            hw_int_reg <= hw_int;
            if (take) begin
                status_exl_reg <= 1'b1;
                cause_exc_reg  <= exc_code;
                // Nested exception keeps the original return point.
                if (!status_exl_reg) begin
                    epc_reg      <= in_delay_slot ? in_pc - 32'd4 : in_pc;
                    cause_bd_reg <= in_delay_slot;
                end
                if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                    badvaddr_reg <= use_data_addr ? in_bad_vaddr : in_pc;
            end else if (eret) begin
                status_exl_reg <= 1'b0;
            end else if (mtc0_ok) begin
                case (cp0_waddr)
                    CP0_STATUS: begin
                        status_im_reg  <= cp0_wdata[STATUS_IM_LO +: 8];
                        status_exl_reg <= cp0_wdata[STATUS_EXL];
                        status_ie_reg  <= cp0_wdata[STATUS_IE];
                    end
                    CP0_CAUSE: cause_ip_sw_reg <= cp0_wdata[CAUSE_IP_LO +: 2];
                    CP0_EPC:   epc_reg         <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        cause_ti_reg;
    logic        toggle_reg;
    logic        count_wr;
    logic        compare_wr;

    assign count_wr   = mtc0_ok && cp0_waddr == CP0_COUNT;
    assign compare_wr = mtc0_ok && cp0_waddr == CP0_COMPARE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            compare_reg  <= '0;
            cause_ti_reg <= 1'b0;
            toggle_reg   <= 1'b0;
        end else begin
            toggle_reg <= ~toggle_reg;
            if (count_wr)        count_reg <= cp0_wdata;
            else if (toggle_reg) count_reg <= count_reg + 32'd1;
            if (compare_wr) begin
                compare_reg  <= cp0_wdata;
                cause_ti_reg <= 1'b0;
            end else if (toggle_reg && !count_wr && (count_reg + 32'd1) == compare_reg) begin
                cause_ti_reg <= 1'b1;
            end
        end
    end

    assign ti_bit     = cause_ti_reg;
    assign count_rd   = count_reg;
    assign compare_rd = compare_reg;
`else
    assign ti_bit     = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    always_comb begin
        status_o                          = '0;
        status_o[STATUS_BEV]              = 1'b1;
        status_o[STATUS_IM_LO +: 8]       = status_im_reg;
        status_o[STATUS_EXL]              = status_exl_reg;
        status_o[STATUS_IE]               = status_ie_reg;
        cause_o                           = '0;
        cause_o[CAUSE_BD]                 = cause_bd_reg;
        cause_o[CAUSE_TI]                 = ti_bit;
        cause_o[CAUSE_IP_LO +: 8]         = cause_ip;
        cause_o[CAUSE_EXC_LO +: 5]        = cause_exc_reg;
    end

    assign epc_o = epc_reg;

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_reg;
            CP0_COUNT:    cp0_rdata = count_rd;
            CP0_COMPARE:  cp0_rdata = compare_rd;
            CP0_STATUS:   cp0_rdata = status_o;
            CP0_CAUSE:    cp0_rdata = cause_o;
            CP0_EPC:      cp0_rdata = epc_reg;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mem_exception_cp0.sv
// Scoreboard bench for mem_exception_cp0: directed scenarios then random traffic,
// checked against a field-level CP0 model. Honours CP0_TIMER_EN like the design.
module tb_mem_exception_cp0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [8:0]  in_except;
    logic [31:0] in_pc;
    logic        in_delay_slot;
    logic [31:0] in_bad_vaddr;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;

    mem_exception_cp0 #(.EXC_VECTOR(VEC)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_except     (in_except),
        .in_pc         (in_pc),
        .in_delay_slot (in_delay_slot),
        .in_bad_vaddr  (in_bad_vaddr),
        .hw_int        (hw_int),
        .mtc0_we       (mtc0_we),
        .cp0_waddr     (cp0_waddr),
        .cp0_wdata     (cp0_wdata),
        .cp0_raddr     (cp0_raddr),
        .cp0_rdata     (cp0_rdata),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .epc_o         (epc_o),
        .status_o      (status_o),
        .cause_o       (cause_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_toggle;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_count, m_compare;

    int prio_bit[7]  = '{0, 1, 2, 3, 5, 6, 7};
    int prio_code[7] = '{4, 10, 8, 9, 12, 4, 5};

    function automatic void model_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_toggle = 0;
        m_ipsw = '0; m_hw = '0; m_code = '0;
        m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Returns ExcCode of the winning exception or -1; src = vector bit, -2 for interrupt.
    function automatic int m_pick(output int src);
        src = -1;
        if (!in_valid) return -1;
        if (m_ie && !m_exl && (m_ip() & m_im) != 8'd0) begin
            src = -2;
            return 0;
        end
        for (int k = 0; k < 7; k++)
            if (in_except[prio_bit[k]]) begin
                src = prio_bit[k];
                return prio_code[k];
            end
        return -1;
    endfunction

    function automatic void model_edge();
        int   src;
        int   code;
        logic er;
        logic wr_ok;
        code  = m_pick(src);
        er    = in_valid && in_except[4] && code < 0;
        wr_ok = mtc0_we && code < 0 && !er;
`ifdef CP0_TIMER_EN
        if (wr_ok && cp0_waddr == 5'd9) m_count = cp0_wdata;
        else if (m_toggle) begin
            m_count = m_count + 1;
            if (m_count == m_compare) m_ti = 1;
        end
        if (wr_ok && cp0_waddr == 5'd11) begin
            m_compare = cp0_wdata;
            m_ti = 0;
        end
        m_toggle = !m_toggle;
`endif
        if (code >= 0) begin
            if (!m_exl) begin
                m_epc = in_delay_slot ? in_pc - 32'd4 : in_pc;
                m_bd  = in_delay_slot;
            end
            m_exl  = 1;
            m_code = 5'(code);
            if (src == 0) m_badv = in_pc;
            else if (src == 6 || src == 7) m_badv = in_bad_vaddr;
        end else if (er) begin
            m_exl = 0;
        end else if (wr_ok) begin
            case (cp0_waddr)
                5'd12: begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                5'd13: m_ipsw = cp0_wdata[9:8];
                5'd14: m_epc = cp0_wdata;
                default: ;
            endcase
        end
        m_hw = hw_int;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        flush;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] rdata;
        logic [4:0]  raddr;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp();
        exp_t e;
        int   src;
        int   code;
        logic er;
        code     = m_pick(src);
        er       = in_valid && in_except[4] && code < 0;
        e.flush  = (code >= 0) || er;
        e.rpc    = (code >= 0) ? VEC : (er ? m_epc : 32'd0);
        e.epc    = m_epc;
        e.status = m_status();
        e.cause  = m_cause();
        e.rdata  = m_rd(cp0_raddr);
        e.raddr  = cp0_raddr;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("flush", {31'd0, flush}, {31'd0, e.flush});
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("epc_o", epc_o, e.epc);
                chk("status_o", status_o, e.status);
                chk("cause_o", cause_o, e.cause);
                chk($sformatf("cp0_rdata[%0d]", e.raddr), cp0_rdata, e.rdata);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic apply(input logic v, input logic [8:0] ex, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bad, input logic [5:0] hw,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra);
        cycle();
        in_valid = v; in_except = ex; in_pc = pc; in_delay_slot = ds;
        in_bad_vaddr = bad; hw_int = hw; mtc0_we = we; cp0_waddr = wa;
        cp0_wdata = wd; cp0_raddr = ra;
        push_exp();
        #1;
    endtask

    task automatic idle(input logic [4:0] ra);
        apply(0, 9'h000, 32'd0, 0, 32'd0, 6'd0, 0, 5'd0, 32'd0, ra);
    endtask

    task automatic eret_now();
        apply(1, 9'h010, 32'h8000_0000, 0, 32'd0, 6'd0, 0, 5'd0, 32'd0, 5'd12);
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [7];
        regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        regs[6] = 5'($urandom_range(0, 31));
        return regs[$urandom_range(0, 6)];
    endfunction

    task automatic random_step();
        logic [8:0] ex;
        for (int b = 0; b < 9; b++) ex[b] = ($urandom_range(0, 7) == 0);
        apply($urandom_range(0, 9) < 8, ex, $urandom, 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0,
              $urandom_range(0, 3) == 0, pick_reg(), $urandom, pick_reg());
    endtask

    task automatic reset_mid();
        cycle();
        in_valid = 1; in_except = 9'h020; in_pc = 32'h8000_0500; in_delay_slot = 0;
        mtc0_we = 0; hw_int = 6'd0; cp0_raddr = 5'd12;
        #1;
        rst = 1;
        #1;
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_redirect", redirect_pc, 32'd0);
        chk("rst_mid_status", status_o, 32'h0040_0000);
        chk("rst_mid_epc", epc_o, 32'd0);
        chk("rst_mid_cause", cause_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        in_valid = 0; in_except = '0;
        push_exp();
        #1;
    endtask

    initial begin
        rst = 1;
        in_valid = 0; in_except = '0; in_pc = '0; in_delay_slot = 0; in_bad_vaddr = '0;
        hw_int = '0; mtc0_we = 0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = 5'd8;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("reset_status", status_o, 32'h0040_0000);
        chk("reset_cause", cause_o, 32'd0);
        chk("reset_epc", epc_o, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_redirect", redirect_pc, 32'd0);
        chk("reset_badvaddr", cp0_rdata, 32'd0);
        push_exp();

        // Overflow, then ERET back to it
        apply(1, 9'h020, 32'h8000_0100, 0, 32'd0, 6'd0, 0, 5'd0, 32'd0, 5'd14);
        chk("ov_flush", {31'd0, flush}, 32'd1);
        chk("ov_redirect", redirect_pc, VEC);
        idle(5'd13);
        chk("ov_epc", epc_o, 32'h8000_0100);
        chk("ov_code", {27'd0, cause_o[6:2]}, 32'd12);
        chk("ov_exl", {31'd0, status_o[1]}, 32'd1);
        eret_now();
        chk("eret_redirect", redirect_pc, 32'h8000_0100);
        idle(5'd12);
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // Delay-slot syscall
        apply(1, 9'h004, 32'h8000_0204, 1, 32'd0, 6'd0, 0, 5'd0, 32'd0, 5'd14);
        idle(5'd13);
        chk("ds_epc", epc_o, 32'h8000_0200);
        chk("ds_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("ds_code", {27'd0, cause_o[6:2]}, 32'd8);
        eret_now();

        // RI beats Ov
        apply(1, 9'h022, 32'h8000_0300, 0, 32'd0, 6'd0, 0, 5'd0, 32'd0, 5'd13);
        idle(5'd13);
        chk("ri_ov_code", {27'd0, cause_o[6:2]}, 32'd10);
        eret_now();

        // Store AdES
        apply(1, 9'h080, 32'h8000_0400, 0, 32'h1000_0003, 6'd0, 0, 5'd0, 32'd0, 5'd8);
        idle(5'd8);
        chk("ades_badvaddr", cp0_rdata, 32'h1000_0003);
        chk("ades_code", {27'd0, cause_o[6:2]}, 32'd5);
        eret_now();

        // ERET together with Ov: exception wins
        apply(1, 9'h030, 32'h8000_0440, 0, 32'd0, 6'd0, 0, 5'd0, 32'd0, 5'd14);
        chk("eret_ov_redirect", redirect_pc, VEC);
        idle(5'd13);
        eret_now();

        // Interrupt through IP[2]
        apply(0, 9'h000, 32'd0, 0, 32'd0, 6'd0, 1, 5'd12, 32'h0040_0401, 5'd12);
        apply(1, 9'h000, 32'h8000_0600, 0, 32'd0, 6'd1, 0, 5'd0, 32'd0, 5'd13);
        chk("int_not_yet", {31'd0, flush}, 32'd0);
        apply(1, 9'h000, 32'h8000_0604, 0, 32'd0, 6'd1, 0, 5'd0, 32'd0, 5'd13);
        chk("int_taken", {31'd0, flush}, 32'd1);
        apply(1, 9'h000, 32'h8000_0608, 0, 32'd0, 6'd1, 0, 5'd0, 32'd0, 5'd13);
        chk("int_masked_exl", {31'd0, flush}, 32'd0);
        chk("int_code", {27'd0, cause_o[6:2]}, 32'd0);
        eret_now();

`ifdef CP0_TIMER_EN
        apply(0, 9'h000, 32'd0, 0, 32'd0, 6'd0, 1, 5'd11, 32'd5, 5'd9);
        apply(0, 9'h000, 32'd0, 0, 32'd0, 6'd0, 1, 5'd9, 32'd0, 5'd9);
        repeat (12) idle(5'd9);
        chk("timer_ti_set", {31'd0, cause_o[30]}, 32'd1);
        apply(0, 9'h000, 32'd0, 0, 32'd0, 6'd0, 1, 5'd11, 32'hFFFF_0000, 5'd11);
        idle(5'd11);
        chk("timer_ti_clr", {31'd0, cause_o[30]}, 32'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) reset_mid();
            else random_step();
        end
        idle(5'd12);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
